ifetch: RTL and testbench

Instruction fetch stage, directly upstream of `imem` and downstream of the redirect logic. It owns the program counter and presents `im_addr` to `imem`, whose `im_inst` read is combinational in the same cycle. Each `{pc, inst, fault}` packet is captured into a 2-entry queue and handed to decode over a valid/ready handshake. It also handles branch/jump redirects, queue flush, and alignment/range faults.

---
 rtl/cowcat_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 50 +++++
 rtl/ifetch.sv | 85 ++++++++
 tb/tb_ifetch.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cowcat_pkg.sv
// Shared definitions for the fetch front end: packet layout, fault encodings
// and the reset PC default used by ifetch.
package cowcat_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [1:0]  FAULT_MISALIGN   = 2'b01;
    localparam logic [1:0]  FAULT_RANGE      = 2'b10;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One fetched packet as it travels to decode: 32 + 32 + 2 = 66 bits.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  fault;
    } fetch_pkt_t;

    // Fault bits for a word fetch at pc; last_word is the highest legal word address.
    function automatic logic [1:0] fetch_fault(input logic [31:0] pc,
                                               input logic [31:0] last_word);
        logic [1:0] f;
        f    = '0;
        f[0] = (pc[1:0] != 2'b00);
        f[1] = (pc > last_word);
        return f;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO holding fetched packets between the PC stage and decode.
// Flush empties it in one cycle; head reads as all-zero while empty.
module fetch_fifo
    import cowcat_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  fetch_pkt_t din,
    output logic [1:0] count,
    output fetch_pkt_t head,
    output logic       full,
    output logic       empty
);

    fetch_pkt_t mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else if (flush) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: storage is deliberately left without reset; the head mux hides stale data while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign count = count_q;
    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, checks alignment/range, queues packets
// for decode and gives redirects priority over push and pop.
module ifetch
    import cowcat_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] im_addr,
    input  logic [31:0] im_inst,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_inst,
    output logic [1:0]  dec_fault,
    output logic        fetch_halted
);

    localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);

    logic [31:0] pc_q;
    logic        halted_q;
    logic [1:0]  fault;
    logic        push;
    logic        pop;
    fetch_pkt_t  pkt;
    fetch_pkt_t  head;
    logic [1:0]  count;
    logic        full;
    logic        empty;

    assign fault = fetch_fault(pc_q, LAST_WORD);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pkt       = '0;
        pkt.pc    = pc_q;
        pkt.fault = fault;
        pkt.inst  = (fault != 2'b00) ? NOP_INST : im_inst;
    end

    // Redirect wins: it blocks both push and pop and hides the head from decode.
    assign pop  = !empty && dec_ready && !redir_valid;
    assign push = !halted_q && !redir_valid && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else if (redir_valid) begin
            pc_q     <= redir_pc;
            halted_q <= 1'b0;
        end else if (push) begin
            if (fault != 2'b00) halted_q <= 1'b1;
            else                pc_q     <= pc_q + 32'd4;
        end
    end

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redir_valid),
        .din   (pkt),
        .count (count),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assert property (@(posedge clk) disable iff (!rst) count <= 2'd2);

    assign im_addr      = pc_q;
    assign dec_valid    = !empty && !redir_valid;
    assign dec_pc       = head.pc;
    assign dec_inst     = head.inst;
    assign dec_fault    = head.fault;
    assign fetch_halted = halted_q;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: the bench models imem, queues expected packets as it
// steers fetch, and a negedge monitor compares every decode handshake.
module tb_ifetch;
    import cowcat_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] im_addr;
    logic [31:0] im_inst;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
    logic [1:0]  dec_fault;
    logic        fetch_halted;

    fetch_pkt_t  exp_q [$];
    fetch_pkt_t  mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    // imem: word i holds 0x1000_0000 + i
    assign im_inst = 32'h1000_0000 + {2'b00, im_addr[31:2]};

    ifetch #(.RESET_PC(32'h0000_0000), .IMEM_BYTES(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .im_addr      (im_addr),
        .im_inst      (im_inst),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_pc       (dec_pc),
        .dec_inst     (dec_inst),
        .dec_fault    (dec_fault),
        .fetch_halted (fetch_halted)
    );

    task automatic expect_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            fetch_pkt_t p;
            p.pc    = start + 32'(4 * i);
            p.inst  = 32'h1000_0000 + {2'b00, p.pc[31:2]};
            p.fault = 2'b00;
            exp_q.push_back(p);
        end
    endtask

    // Scoreboard consumer: every accepted packet must match the next expectation.
    always @(negedge clk) begin
        if (rst && dec_valid && dec_ready && !redir_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pkt: got pc=%h inst=%h fault=%b, required no packet",
                         dec_pc, dec_inst, dec_fault);
            end else begin
                mon_e = exp_q.pop_front();
                if ({dec_pc, dec_inst, dec_fault} !== {mon_e.pc, mon_e.inst, mon_e.fault}) begin
                    n_fail++;
                    $display("FAIL pkt_compare: got pc=%h inst=%h fault=%b, required pc=%h inst=%h fault=%b",
                             dec_pc, dec_inst, dec_fault, mon_e.pc, mon_e.inst, mon_e.fault);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0; dec_ready = 1'b1; redir_valid = 1'b0;
        #12;
        n_tests++;
        if (dec_valid !== 1'b0 || fetch_halted !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got valid=%b halted=%b, required 0 0", dec_valid, fetch_halted);
        end
        n_tests++;
        if (im_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc: got %h, required 00000000", im_addr);
        end
        n_tests++;
        if ({dec_pc, dec_inst, dec_fault} !== 66'h0) begin
            n_fail++; $display("FAIL reset_head: got pc=%h inst=%h fault=%b, required zeros", dec_pc, dec_inst, dec_fault);
        end
        @(negedge clk);
        expect_seq(32'h0, 40);
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
            n_fail++; $display("FAIL first_valid: got valid=%b pc=%h, required 1 00000000", dec_valid, dec_pc);
        end
    endtask

    task automatic test_stream();
        repeat (6) @(posedge clk);
        #1;
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h18) begin
            n_fail++; $display("FAIL stream_pc: got valid=%b pc=%h, required 1 00000018", dec_valid, dec_pc);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] frozen;
        dec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        frozen = exp_q[0].pc + 32'd8;
        n_tests++;
        if (im_addr !== frozen) begin
            n_fail++; $display("FAIL bp_freeze: got im_addr=%h, required %h", im_addr, frozen);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (im_addr !== frozen || dec_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold: got im_addr=%h valid=%b, required %h 1", im_addr, dec_valid, frozen);
        end
        dec_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_redirect_full();
        dec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        redir_valid = 1'b1; redir_pc = 32'h40; dec_ready = 1'b1;
        exp_q.delete();
        expect_seq(32'h40, 12);
        #1;
        n_tests++;
        if (dec_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_mask: got valid=%b, required 0", dec_valid);
        end
        @(posedge clk); #1;
        redir_valid = 1'b0;
        n_tests++;
        if (dec_valid !== 1'b0 || im_addr !== 32'h40) begin
            n_fail++; $display("FAIL redir_n1: got valid=%b im_addr=%h, required 0 00000040", dec_valid, im_addr);
        end
        @(posedge clk); #1;
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h40) begin
            n_fail++; $display("FAIL redir_n2: got valid=%b pc=%h, required 1 00000040", dec_valid, dec_pc);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_misaligned();
        fetch_pkt_t p;
        redir_valid = 1'b1; redir_pc = 32'h42;
        exp_q.delete();
        p.pc = 32'h42; p.inst = NOP_INST; p.fault = FAULT_MISALIGN;
        exp_q.push_back(p);
        @(posedge clk); #1;
        redir_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h42 || dec_inst !== 32'h0000_0013 || dec_fault !== 2'b01) begin
            n_fail++; $display("FAIL misalign_pkt: got valid=%b pc=%h inst=%h fault=%b, required 1 00000042 00000013 01",
                               dec_valid, dec_pc, dec_inst, dec_fault);
        end
        n_tests++;
        if (fetch_halted !== 1'b1) begin
            n_fail++; $display("FAIL misalign_halt: got %b, required 1", fetch_halted);
        end
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (dec_valid !== 1'b0 || fetch_halted !== 1'b1 || im_addr !== 32'h42 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL misalign_stop: got valid=%b halted=%b im_addr=%h pending=%0d, required 0 1 00000042 0",
                               dec_valid, fetch_halted, im_addr, exp_q.size());
        end
        redir_valid = 1'b1; redir_pc = 32'h0;
        expect_seq(32'h0, 8);
        @(posedge clk); #1;
        redir_valid = 1'b0;
        n_tests++;
        if (fetch_halted !== 1'b0) begin
            n_fail++; $display("FAIL resume_halt: got %b, required 0", fetch_halted);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_range();
        fetch_pkt_t p;
        redir_valid = 1'b1; redir_pc = 32'hF0;
        exp_q.delete();
        expect_seq(32'hF0, 4);
        p.pc = 32'h100; p.inst = NOP_INST; p.fault = FAULT_RANGE;
        exp_q.push_back(p);
        @(posedge clk); #1;
        redir_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h100 || dec_fault !== 2'b10 || dec_inst !== 32'h0000_0013) begin
            n_fail++; $display("FAIL range_pkt: got valid=%b pc=%h inst=%h fault=%b, required 1 00000100 00000013 10",
                               dec_valid, dec_pc, dec_inst, dec_fault);
        end
        n_tests++;
        if (fetch_halted !== 1'b1) begin
            n_fail++; $display("FAIL range_halt: got %b, required 1", fetch_halted);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (dec_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL range_stop: got valid=%b pending=%0d, required 0 0", dec_valid, exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        redir_valid = 1'b1; redir_pc = 32'h0;
        exp_q.delete();
        expect_seq(32'h0, 20);
        @(posedge clk); #1;
        redir_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (dec_valid !== 1'b0 || im_addr !== 32'h0 || fetch_halted !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got valid=%b im_addr=%h halted=%b, required 0 00000000 0",
                               dec_valid, im_addr, fetch_halted);
        end
        exp_q.delete();
        @(negedge clk);
        expect_seq(32'h0, 10);
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_resume: got valid=%b pc=%h, required 1 00000000", dec_valid, dec_pc);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_misaligned();
        test_range();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
